riscv_cm_ctrl: RTL

RISCV_CM_CTRL -- requirements
Module: riscv_cm_ctrl

---
 rtl/riscv_state_pkg.sv | 28 ++
 rtl/riscv_cm_timer.sv | 31 +++
 rtl/riscv_cm_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/riscv_state_pkg.sv
// Shared types for the cache-maintenance controller: FSM state encoding,
// the captured operation set, and the "next flagged operation" helper.
package riscv_state_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DC_CLEAN = 3'd1,
    DC_INV   = 3'd2,
    IC_INV   = 3'd3,
    RESTART  = 3'd4
  } cm_state_t;

  typedef struct packed {
    logic dc_clean;
    logic dc_inv;
    logic ic_inv;
  } cm_ops_t;

  // Operations always run in the order DC_CLEAN, DC_INV, IC_INV; any flagged
  // operation that lies after the current state is the next one to run.
  function automatic cm_state_t cm_next_op(cm_state_t cur, cm_ops_t ops);
    cm_next_op = RESTART;
    if (ops.ic_inv && (cur == IDLE || cur == DC_CLEAN || cur == DC_INV)) cm_next_op = IC_INV;
    if (ops.dc_inv && (cur == IDLE || cur == DC_CLEAN))                  cm_next_op = DC_INV;
    if (ops.dc_clean && (cur == IDLE))                                    cm_next_op = DC_CLEAN;
  endfunction

endpackage

// File: rtl/riscv_cm_timer.sv
// Wait-state watchdog: counts cycles spent in one wait state without an ack
// and flags expiry on the TIMEOUT_CYCLES-th such cycle.
module riscv_cm_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wait_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q;

  assign expired_o = wait_i && !ack_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Leaving a wait state (ack or expiry) zeroes the count, so the next wait
  // state starts from zero even when entered back-to-back.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!wait_i || ack_i || expired_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_cm_ctrl.sv
// Cache-maintenance sequencer: stalls the pipeline, walks the requested cache
// operations in fixed order, then redirects fetch. Define RV_CM_TIMEOUT_EN to add the watchdog.
module riscv_cm_ctrl
  import riscv_state_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            st_flush_i,
  input  logic            cm_dc_clean_i,
  input  logic            cm_dc_invalidate_i,
  input  logic            cm_ic_invalidate_i,
  input  logic [XLEN-1:0] bu_nxt_pc_i,
  output logic            dc_clean_req_o,
  input  logic            dc_clean_ack_i,
  output logic            dc_inv_req_o,
  input  logic            dc_inv_ack_i,
  output logic            ic_inv_req_o,
  input  logic            ic_inv_ack_i,
  output logic            cm_stall_o,
  output logic            cm_busy_o,
  output logic            cm_restart_o,
  output logic [XLEN-1:0] cm_restart_pc_o,
  output logic            cm_timeout_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("riscv_cm_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  cm_state_t       state_q, state_d;
  cm_ops_t         ops_q, ops_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            abort_q, abort_d;
  logic            trigger, in_wait, ack, timeout;

  assign trigger = cm_dc_clean_i | cm_dc_invalidate_i | cm_ic_invalidate_i;
  assign in_wait = (state_q == DC_CLEAN) || (state_q == DC_INV) || (state_q == IC_INV);

  always_comb begin
    ack = 1'b0;
    unique case (state_q)
      DC_CLEAN: ack = dc_clean_ack_i;
      DC_INV:   ack = dc_inv_ack_i;
      IC_INV:   ack = ic_inv_ack_i;
      default:  ack = 1'b0;
    endcase
  end

`ifdef RV_CM_TIMEOUT_EN
  riscv_cm_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wait_i   (in_wait),
    .ack_i    (ack),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    pc_d    = pc_q;
    abort_d = abort_q | ((state_q != IDLE) & st_flush_i);
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          ops_d   = '{dc_clean: cm_dc_clean_i, dc_inv: cm_dc_invalidate_i, ic_inv: cm_ic_invalidate_i};
          pc_d    = bu_nxt_pc_i;
          abort_d = st_flush_i;
          state_d = cm_next_op(IDLE, ops_d);
        end
      end
      DC_CLEAN, DC_INV, IC_INV: begin
        if (ack || timeout) state_d = cm_next_op(state_q, ops_q);
      end
      RESTART: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, with an
  // asynchronous active-low clear of every register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ops_q   <= '0;
      pc_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      pc_q    <= pc_d;
      abort_q <= abort_d;
    end
  end

  // Requests decode straight from state so a reset removes them at once.
  assign dc_clean_req_o  = (state_q == DC_CLEAN);
  assign dc_inv_req_o    = (state_q == DC_INV);
  assign ic_inv_req_o    = (state_q == IC_INV);
  assign cm_busy_o       = (state_q != IDLE);
  assign cm_stall_o      = cm_busy_o | trigger;
  assign cm_restart_o    = (state_q == RESTART) && !abort_q;
  assign cm_restart_pc_o = pc_q;
  assign cm_timeout_o    = timeout;

endmodule
